// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between the JTAG
// bridge (port A) and the core (port B), with RD_LAT-cycle read latency handling.
module sram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [DATA_W-1:0] sram_data_out,
  output logic              sram_write_enable,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake: a requester raises req with we/addr/wdata stable and keeps them so
  // until its one-cycle ack; req is sampled only in IDLE, and once granted the
  // access always completes with an ack even if req drops.

  localparam int CNT_W = $clog2(RD_LAT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              ptr_q, ptr_d;   // 0: A wins a tie, 1: B wins a tie
  logic              gnt_q, gnt_d;   // 0: A granted, 1: B granted
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              win_b;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    cnt_d     = cnt_q;
    win_b     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          win_b   = (a_req && b_req) ? ptr_q : b_req;
          gnt_d   = win_b;
          we_d    = win_b ? b_we : a_we;
          addr_d  = win_b ? b_addr : a_addr;
          wdata_d = win_b ? b_wdata : a_wdata;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_ACK;
        end else begin
          cnt_d   = CNT_W'(RD_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // Last wait cycle: the SRAM output now reflects the latched address.
        if (cnt_q == CNT_W'(1)) begin
          if (gnt_q) b_rdata_d = sram_data_out;
          else       a_rdata_d = sram_data_out;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        ptr_d   = ~gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= 1'b0;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sram_address      = addr_q;
  assign sram_data_in      = wdata_q;
  assign sram_write_enable = (state_q == S_ACCESS) && we_q;
  assign a_ack             = (state_q == S_ACK) && !gnt_q;
  assign b_ack             = (state_q == S_ACK) && gnt_q;
  assign a_rdata           = a_rdata_q;
  assign b_rdata           = b_rdata_q;
  assign busy              = (state_q != S_IDLE);
  assign state_dbg         = state_q;

endmodule
